// File: rtl/n64_poll_sequencer_if.sv
// Signal bundle between the board top level and the N64 poll sequencer.
// The link pin pair (Data_In/Data_Oe) travels with the control and status signals.
interface n64_poll_sequencer_if;
    logic        Enable;
    logic        Poll_Now;
    logic        Data_In;
    logic        Data_Oe;
    logic        Rx_Enable;
    logic        Busy;
    logic [31:0] Buttons;
    logic        Valid;
    logic        Timeout;

    modport master (
        output Enable, Poll_Now, Data_In,
        input  Data_Oe, Rx_Enable, Busy, Buttons, Valid, Timeout
    );

    modport slave (
        input  Enable, Poll_Now, Data_In,
        output Data_Oe, Rx_Enable, Busy, Buttons, Valid, Timeout
    );
endinterface

// File: rtl/n64_poll_sequencer.sv
// N64 controller link transaction controller: sends the 0x01 status poll, then
// receives and publishes the 32-bit reply, aborting if the controller goes quiet.
module n64_poll_sequencer #(
    parameter int CYC_PER_US  = 12,
    parameter int POLL_CYCLES = 200000,
    parameter int TIMEOUT_US  = 200
) (
    input logic                   clk,
    input logic                   Reset,
    n64_poll_sequencer_if.slave   bus
);

    localparam int BIT_CYC = 4 * CYC_PER_US;
    localparam int CW      = $clog2(BIT_CYC);
    localparam int TO_CYC  = TIMEOUT_US * CYC_PER_US;
    localparam int TW      = $clog2(TO_CYC + 1);
    localparam int PW      = $clog2(POLL_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] ONE_US    = CW'(CYC_PER_US);
    localparam logic [CW-1:0] THREE_US  = CW'(3 * CYC_PER_US);
    localparam logic [CW-1:0] US_LAST   = CW'(CYC_PER_US - 1);
    localparam logic [CW-1:0] SAMP_LAST = CW'(2 * CYC_PER_US - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TO_CYC - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TX_BIT  = 3'd1;
    localparam logic [2:0] TX_STOP = 3'd2;
    localparam logic [2:0] RX_WAIT = 3'd3;
    localparam logic [2:0] RX_SAMP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] ABORT   = 3'd6;

    logic [2:0]    state;
    logic          sync_q0;
    logic          sync_q1;
    logic [PW-1:0] poll_cnt;
    logic [CW-1:0] bit_cnt;
    logic [4:0]    bit_idx;
    logic [TW-1:0] to_cnt;
    logic [31:0]   shift_reg;

    logic          fall;
    logic          start;
    logic          bit_last;
    logic [CW-1:0] cnt_nxt;
    logic [4:0]    idx_nxt;
    logic          oe_nxt;

    // Data_Oe is registered, so the TX drive level is computed for the coming cycle.
    always_comb begin
        fall     = sync_q1 & ~sync_q0;
        start    = (state == IDLE) && (bus.Poll_Now || (poll_cnt == POLL_LAST));
        bit_last = (bit_cnt == BIT_LAST);
        cnt_nxt  = bit_last ? '0 : bit_cnt + CW'(1);
        idx_nxt  = bit_last ? bit_idx + 5'd1 : bit_idx;
        oe_nxt   = cnt_nxt < ((idx_nxt == 5'd7) ? ONE_US : THREE_US);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync_q0 <= 1'b1;
            sync_q1 <= 1'b1;
        end else begin
            sync_q0 <= bus.Data_In;
            sync_q1 <= sync_q0;
        end
    end

    // The interval only accumulates idle time, so a poll never queues behind a busy one.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            poll_cnt <= '0;
        end else if ((state != IDLE) || start || !bus.Enable) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            to_cnt        <= '0;
            shift_reg     <= '0;
            bus.Data_Oe   <= 1'b0;
            bus.Rx_Enable <= 1'b0;
            bus.Busy      <= 1'b0;
            bus.Buttons   <= '0;
            bus.Valid     <= 1'b0;
            bus.Timeout   <= 1'b0;
        end else begin
            bus.Valid   <= 1'b0;
            bus.Timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= TX_BIT;
                        bus.Busy    <= 1'b1;
                        bus.Data_Oe <= 1'b1;
                        bit_cnt     <= '0;
                        bit_idx     <= '0;
                        shift_reg   <= '0;
                    end
                end
                TX_BIT: begin
                    if (bit_last && (bit_idx == 5'd7)) begin
                        state       <= TX_STOP;
                        bit_cnt     <= '0;
                        bus.Data_Oe <= 1'b1;
                    end else begin
                        bit_cnt     <= cnt_nxt;
                        bit_idx     <= idx_nxt;
                        bus.Data_Oe <= oe_nxt;
                    end
                end
                TX_STOP: begin
                    if (bit_cnt == US_LAST) begin
                        state         <= RX_WAIT;
                        bus.Data_Oe   <= 1'b0;
                        bus.Rx_Enable <= 1'b1;
                        to_cnt        <= TO_LOAD;
                        bit_idx       <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                RX_WAIT: begin
                    if (fall) begin
                        state   <= RX_SAMP;
                        bit_cnt <= '0;
                        to_cnt  <= TO_LOAD;
                    end else if (to_cnt == '0) begin
                        state <= ABORT;
                    end else begin
                        to_cnt <= to_cnt - TW'(1);
                    end
                end
                // Sampling mid-cell separates a 1 us low (one) from a 3 us low (zero).
                RX_SAMP: begin
                    if (bit_cnt == SAMP_LAST) begin
                        shift_reg <= {shift_reg[30:0], sync_q0};
                        if (bit_idx == 5'd31) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            state   <= RX_WAIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DONE: begin
                    bus.Buttons   <= shift_reg;
                    bus.Valid     <= 1'b1;
                    bus.Busy      <= 1'b0;
                    bus.Rx_Enable <= 1'b0;
                    state         <= IDLE;
                end
                ABORT: begin
                    bus.Timeout   <= 1'b1;
                    bus.Busy      <= 1'b0;
                    bus.Rx_Enable <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    bus.Data_Oe   <= 1'b0;
                    bus.Rx_Enable <= 1'b0;
                    bus.Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
